// File: rtl/hmmm_muldiv.sv
// Iterative multiply/divide/modulo unit: shift-add multiply and restoring division,
// one bit per cycle, with sign correction and divide-by-zero / reserved-op short path.
module hmmm_muldiv #(
    parameter int unsigned WIDTH     = 16,
    parameter bit          SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero,
    output logic             illegal_op
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    typedef enum logic [1:0] {OP_MUL = 2'b00, OP_DIV = 2'b01, OP_MOD = 2'b10, OP_RSV = 2'b11} op_t;

    state_t             state, state_nxt;
    op_t                op_q;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;
    logic [WIDTH-1:0]   raw_a;
    logic               neg_q, dbz_q, ill_q;

    logic               accept, sgn_req, a_neg, b_neg, is_dz, is_ill;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum, div_part, div_diff;
    logic [2*WIDTH-1:0] mul_next, div_next;
    logic [WIDTH-1:0]   raw_res, signed_res, fix_val;

    assign busy = (state == CALC) || (state == FIX);
    assign done = (state == DONE);

    always_comb begin
        accept  = start && !busy;
        sgn_req = signed_op && SIGNED_EN;
        a_neg   = sgn_req && src_a[WIDTH-1];
        b_neg   = sgn_req && src_b[WIDTH-1];
        mag_a   = a_neg ? ('0 - src_a) : src_a;
        mag_b   = b_neg ? ('0 - src_b) : src_b;
        is_ill  = (op == OP_RSV);
        is_dz   = ((op == OP_DIV) || (op == OP_MOD)) && (src_b == '0);
    end

    // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV/MOD
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};
        div_part = acc[2*WIDTH-1:WIDTH-1];
        div_diff = div_part - {1'b0, opb};
        if (!div_diff[WIDTH])
            div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            div_next = {div_part[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end

    always_comb begin
        raw_res    = (op_q == OP_MOD) ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
        signed_res = neg_q ? ('0 - raw_res) : raw_res;
        fix_val    = signed_res;
        if (ill_q)
            fix_val = '0;
        else if (dbz_q)
            fix_val = (op_q == OP_DIV) ? '1 : raw_a;
    end

    // Short-path ops spend their single busy cycle in FIX, which resolves them from the flags
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (accept)
                    state_nxt = (is_ill || is_dz) ? FIX : CALC;
                else
                    state_nxt = IDLE;
            end
            CALC:    if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q        <= OP_MUL;
            cnt         <= '0;
            acc         <= '0;
            opb         <= '0;
            raw_a       <= '0;
            neg_q       <= 1'b0;
            dbz_q       <= 1'b0;
            ill_q       <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
        end else begin
            if (accept) begin
                op_q  <= op_t'(op);
                cnt   <= '0;
                raw_a <= src_a;
                dbz_q <= is_dz;
                ill_q <= is_ill;
                neg_q <= (op == OP_MOD) ? a_neg : (a_neg ^ b_neg);
                if (op == OP_MUL) begin
                    acc <= {{WIDTH{1'b0}}, mag_b};
                    opb <= mag_a;
                end else begin
                    acc <= {{WIDTH{1'b0}}, mag_a};
                    opb <= mag_b;
                end
            end else if (state == CALC) begin
                cnt <= cnt + 1'b1;
                acc <= (op_q == OP_MUL) ? mul_next : div_next;
            end
            if (state == FIX) begin
                result      <= fix_val;
                div_by_zero <= dbz_q;
                illegal_op  <= ill_q;
            end
        end
    end

endmodule

// File: tb/tb_hmmm_muldiv.sv
// Scoreboard bench for hmmm_muldiv: stimulus pushes hand-computed results,
// per-instance monitors pop and compare on every done pulse.
module tb_hmmm_muldiv;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0, start_u = 1'b0;
    logic [1:0]  op = 2'b00;
    logic        signed_op = 1'b0;
    logic [15:0] src_a = '0, src_b = '0;
    logic        busy, done, div_by_zero, illegal_op;
    logic [15:0] result;
    logic        busy_u, done_u, div_by_zero_u, illegal_op_u;
    logic [15:0] result_u;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] res;
        logic        dz;
        logic        il;
        int          acc_cyc;
        int          lat;
        int          id;
    } exp_t;

    exp_t q[$];
    exp_t q_u[$];

    hmmm_muldiv #(.WIDTH(16), .SIGNED_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .signed_op(signed_op),
        .src_a(src_a), .src_b(src_b), .busy(busy), .done(done), .result(result),
        .div_by_zero(div_by_zero), .illegal_op(illegal_op)
    );

    hmmm_muldiv #(.WIDTH(16), .SIGNED_EN(1'b0)) dut_u (
        .clk(clk), .reset(reset), .start(start_u), .op(op), .signed_op(signed_op),
        .src_a(src_a), .src_b(src_b), .busy(busy_u), .done(done_u), .result(result_u),
        .div_by_zero(div_by_zero_u), .illegal_op(illegal_op_u)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic compare(input int id, input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL id%0d %s: got %h want %h", id, name, got, want);
        end
    endtask

    task automatic check_entry(input exp_t e, input logic [15:0] r, input logic dz, input logic il);
        compare(e.id, "result", r, e.res);
        compare(e.id, "div_by_zero", 16'(dz), 16'(e.dz));
        compare(e.id, "illegal_op", 16'(il), 16'(e.il));
        compare(e.id, "latency", 16'(cyc - e.acc_cyc), 16'(e.lat));
    endtask

    always @(negedge clk) begin
        if (reset && done) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL spurious_done: got done=1 want no pending op");
            end else begin
                check_entry(q.pop_front(), result, div_by_zero, illegal_op);
            end
        end
    end

    always @(negedge clk) begin
        if (reset && done_u) begin
            if (q_u.size() == 0) begin
                checks++; errors++;
                $display("FAIL spurious_done_u: got done=1 want no pending op");
            end else begin
                check_entry(q_u.pop_front(), result_u, div_by_zero_u, illegal_op_u);
            end
        end
    end

    // Drives one request; the accept edge is the next rising edge.
    task automatic issue(input bit unit, input logic [1:0] o, input logic s,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] r, input logic dz, input logic il, input int id);
        exp_t e;
        op = o; signed_op = s; src_a = a; src_b = b;
        if (unit) start_u = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start_u = 1'b0;
        e.res = r; e.dz = dz; e.il = il; e.acc_cyc = cyc; e.id = id;
        e.lat = (dz || il) ? 1 : 17;
        if (unit) q_u.push_back(e); else q.push_back(e);
    endtask

    task automatic wait_done(input bit unit, output int busy_cnt);
        bit seen;
        busy_cnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (unit ? busy_u : busy) busy_cnt++;
            if (unit ? done_u : done) seen = 1'b1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done want done within 200 cycles");
        end
    endtask

    initial begin
        int bc;
        #2;
        compare(0, "rst_busy", 16'(busy), 16'h0);
        compare(0, "rst_done", 16'(done), 16'h0);
        compare(0, "rst_result", result, 16'h0);
        compare(0, "rst_flags", {14'h0, div_by_zero, illegal_op}, 16'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        issue(0, 2'b00, 0, 16'd7, 16'd6, 16'h002A, 0, 0, 1);
        wait_done(0, bc);
        compare(1, "busy_cycles", 16'(bc), 16'd17);
        @(posedge clk); #1;

        issue(0, 2'b01, 0, 16'd100, 16'd7, 16'h000E, 0, 0, 2);  wait_done(0, bc);
        issue(0, 2'b10, 0, 16'd100, 16'd7, 16'h0002, 0, 0, 3);  wait_done(0, bc);
        issue(0, 2'b01, 1, 16'hFFF9, 16'd2, 16'hFFFD, 0, 0, 4); wait_done(0, bc);
        issue(0, 2'b10, 1, 16'hFFF9, 16'd2, 16'hFFFF, 0, 0, 5); wait_done(0, bc);
        issue(0, 2'b00, 1, 16'hFFFD, 16'd5, 16'hFFF1, 0, 0, 6); wait_done(0, bc);
        issue(0, 2'b00, 1, 16'hFFFF, 16'hFFFF, 16'h0001, 0, 0, 7); wait_done(0, bc);
        issue(0, 2'b00, 0, 16'h1234, 16'h0010, 16'h2340, 0, 0, 8); wait_done(0, bc);
        issue(0, 2'b00, 0, 16'h0100, 16'h0100, 16'h0000, 0, 0, 9); wait_done(0, bc);

        repeat (2) @(posedge clk); #1;
        issue(0, 2'b01, 0, 16'd5, 16'd0, 16'hFFFF, 1, 0, 10);
        wait_done(0, bc);
        compare(10, "busy_cycles_short", 16'(bc), 16'd1);
        issue(0, 2'b10, 0, 16'd5, 16'd0, 16'h0005, 1, 0, 11);   wait_done(0, bc);
        issue(0, 2'b10, 1, 16'hFFF9, 16'd0, 16'hFFF9, 1, 0, 12); wait_done(0, bc);
        issue(0, 2'b01, 0, 16'd9, 16'd3, 16'h0003, 0, 0, 13);   wait_done(0, bc);

        issue(0, 2'b01, 1, 16'h8000, 16'hFFFF, 16'h8000, 0, 0, 14); wait_done(0, bc);
        issue(0, 2'b10, 1, 16'h8000, 16'hFFFF, 16'h0000, 0, 0, 15); wait_done(0, bc);
        issue(1, 2'b01, 1, 16'h8000, 16'hFFFF, 16'h0000, 0, 0, 16); wait_done(1, bc);
        issue(1, 2'b10, 1, 16'h8000, 16'hFFFF, 16'h8000, 0, 0, 17); wait_done(1, bc);

        // Starts during a busy MUL must be dropped.
        @(posedge clk); #1;
        issue(0, 2'b00, 0, 16'h0011, 16'd3, 16'h0033, 0, 0, 18);
        repeat (2) @(posedge clk); #1;
        op = 2'b01; src_a = 16'hFFFF; src_b = 16'd2; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (6) @(posedge clk); #1;
        op = 2'b10; src_a = 16'h1111; src_b = 16'd5; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(0, bc);

        // Start held in the DONE cycle is accepted back-to-back.
        @(posedge clk); #1;
        issue(0, 2'b00, 0, 16'd3, 16'd4, 16'h000C, 0, 0, 19);
        wait_done(0, bc);
        issue(0, 2'b01, 0, 16'd100, 16'd7, 16'h000E, 0, 0, 20);
        wait_done(0, bc);
        compare(20, "busy_cycles_b2b", 16'(bc), 16'd17);

        // Mid-operation reset: outputs clear asynchronously, no done follows.
        issue(0, 2'b10, 0, 16'd1000, 16'd3, 16'h0001, 0, 0, 21);
        repeat (7) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        compare(21, "arst_busy", 16'(busy), 16'h0);
        compare(21, "arst_done", 16'(done), 16'h0);
        compare(21, "arst_result", result, 16'h0);
        q.delete();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (25) @(posedge clk);
        #1;

        issue(0, 2'b11, 0, 16'd12, 16'd34, 16'h0000, 0, 1, 22); wait_done(0, bc);
        issue(0, 2'b00, 0, 16'd9, 16'd9, 16'h0051, 0, 0, 23);    wait_done(0, bc);
        compare(23, "flag_cleared", 16'(illegal_op), 16'h0);

        repeat (3) @(posedge clk);
        compare(99, "queue_empty", 16'(q.size() + q_u.size()), 16'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
